// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier and its signed companions:
// state encoding, widths and the conditional two's-complement helper.
`default_nettype none

package mul_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = $clog2(MUL_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_t;

  localparam logic [MUL_WIDTH-1:0] MUL_ONE = {{(MUL_WIDTH-1){1'b0}}, 1'b1};

  // Returns -x when en is set, x otherwise; with en = x[msb] this yields |x|
  // as an unsigned magnitude, so the most negative value maps onto itself.
  function automatic logic [MUL_WIDTH-1:0] cond_neg(
    input logic [MUL_WIDTH-1:0] x,
    input logic                 en
  );
    return en ? (~x + MUL_ONE) : x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_iter.sv
// Radix-2 shift-add 32x32->64 multiplier for MULT/MULTU; signed operation is
// done as a magnitude multiply followed by a conditional final negate.
`default_nettype none

module mul_iter
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [2*WIDTH-1:0] ACC_ONE  = {{(2*WIDTH-1){1'b0}}, 1'b1};

  state_t             state;
  state_t             state_nx;
  logic               neg;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   q;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] result;

  // Operand conditioning: magnitudes only in signed mode.
  always_comb begin
    a_mag  = cond_neg(a, is_signed & a[WIDTH-1]);
    b_mag  = cond_neg(b, is_signed & b[WIDTH-1]);
    addend = q[0] ? m : '0;
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    result = neg ? (~acc + ACC_ONE) : acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (cnt == CNT_LAST) state_nx = SIGN;
      SIGN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg  <= 1'b0;
      m    <= '0;
      q    <= '0;
      acc  <= '0;
      cnt  <= '0;
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            neg <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            m   <= a_mag;
            q   <= b_mag;
            acc <= '0;
            cnt <= '0;
          end
        end
        CALC: begin
          // Carry out of the upper-half add shifts into the top bit.
          acc <= {sum, acc[WIDTH-1:1]};
          q   <= q >> 1;
          cnt <= cnt + CNT_ONE;
        end
        SIGN: begin
          hi   <= result[2*WIDTH-1:WIDTH];
          lo   <= result[WIDTH-1:0];
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_iter.sv
// Scoreboard bench for mul_iter: directed vectors with hand-computed products.
`default_nettype none

module tb_mul_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  mul_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          e0;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT signals a result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      chk("busy_done_excl", {63'd0, busy}, 64'd0);
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got hi=%h lo=%h expected no result", hi, lo);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi", {32'd0, hi}, {32'd0, e.hi});
        chk("lo", {32'd0, lo}, {32'd0, e.lo});
        chk("latency", 64'(cyc), 64'(e.e0 + 33));
      end
    end
  end

  // Presents a request; the next rising edge is the sampling edge.
  task automatic issue(input bit s, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el, input bit push);
    exp_t e;
    @(negedge clk);
    start     = 1'b1;
    is_signed = s;
    a         = x;
    b         = y;
    if (push) begin
      e.hi = eh;
      e.lo = el;
      e.e0 = cyc + 1;
      sb.push_back(e);
    end
  endtask

  // Waits for done (bounded), counting busy cycles; optionally pulses a
  // stray start with new operands at negedge number pulse_at.
  task automatic wait_done(input int pulse_at, output int nbusy);
    nbusy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == pulse_at) begin
        start = 1'b1;
        a     = 32'd5;
        b     = 32'd5;
      end else begin
        start = 1'b0;
      end
      if (done) return;
      if (busy) nbusy++;
    end
    checks++;
    fails++;
    $display("FAIL done_timeout: got no done within 100 cycles expected done");
  endtask

  int nb;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    rst_n = 1'b1;

    issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1);
    wait_done(-1, nb);
    chk("busy_cycles", 64'(nb), 64'd33);  // 32 CALC cycles plus the SIGN cycle

    issue(1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1);
    wait_done(-1, nb);
    issue(0, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB, 1);
    wait_done(-1, nb);
    issue(1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1);
    wait_done(-1, nb);
    issue(1, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    wait_done(-1, nb);

    // Reset mid-operation: outputs clear without a clock edge.
    issue(0, 32'h0000_1234, 32'h0000_0010, 32'd0, 32'd0, 0);
    repeat (12) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_hi", {32'd0, hi}, 64'd0);
    chk("midrst_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(0, 32'd9, 32'd9, 32'd0, 32'd81, 1);
    wait_done(-1, nb);

    issue(0, 32'd0, 32'h1234_5678, 32'd0, 32'd0, 1);
    wait_done(9, nb);
    chk("zero_busy_cycles", 64'(nb), 64'd33);
    a = '0;
    b = '0;

    // Back-to-back: start held high through the done cycle.
    issue(0, 32'd6, 32'd7, 32'd0, 32'd42, 1);
    @(negedge clk);
    a = 32'h0001_0000;
    b = 32'h0001_0000;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        if (done) begin
          exp_t e;
          e.hi = 32'd1;
          e.lo = 32'd0;
          e.e0 = cyc + 1;
          sb.push_back(e);
          seen = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
      if (!seen) begin
        checks++;
        fails++;
        $display("FAIL b2b_timeout: got no done expected done");
      end
    end
    @(negedge clk);
    chk("b2b_no_gap", {63'd0, busy}, 64'd1);
    wait_done(-1, nb);

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
